// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM word address and fills IF/ID.
// Latency: redirect shows on rom_addr 1 cycle later, target in IF/ID 2 cycles later (one bubble).
// Backpressure: stall holds PC and IF/ID in RUN; redirects override stall; HALT ignores stall.
module fetch_ctrl #(
    parameter int unsigned PROG_LEN = 29,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_instr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_off,
    input  logic        jmp_en,
    input  logic [25:0] jmp_idx,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        flush_idex,
    output logic        halted,
    output logic        addr_err,
    output logic [15:0] fetch_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        flush_q, flush_d;
    logic        addr_err_q, addr_err_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    logic        redirect;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] redir_tgt;

    always_comb begin
        br_tgt    = br_pc + 32'd1 + {{16{br_off[15]}}, br_off};
        jmp_tgt   = {6'b0, jmp_idx};
        redirect  = br_taken | jmp_en;
        redir_tgt = br_taken ? br_tgt : jmp_tgt;

        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        flush_d      = 1'b0;
        addr_err_d   = addr_err_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (redirect) begin
            // The wrong-path word sitting in IF/ID is squashed whether or not the target is legal.
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            flush_d      = 1'b1;
            if (redir_tgt < 32'(PROG_LEN)) begin
                pc_d    = redir_tgt;
                state_d = RUN;
            end else begin
                state_d    = HALT;
                addr_err_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (!stall) begin
                ifid_instr_d = rom_instr;
                ifid_pc_d    = pc_q;
                ifid_valid_d = 1'b1;
                if (fetch_cnt_q != 16'hFFFF) begin
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                end
                if (pc_q == 32'(PROG_LEN - 1)) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
        end else begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= 32'd0;
            ifid_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            addr_err_q   <= 1'b0;
            fetch_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            flush_q      <= flush_d;
            addr_err_q   <= addr_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign rom_addr   = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign flush_idex = flush_q;
    assign halted     = (state_q == HALT);
    assign addr_err   = addr_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table of per-edge vectors plus a fetch-counter saturation run.
// ROM model returns 0xA0000000 | address so every delivered word identifies its index.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_off;
    logic        jmp_en;
    logic [25:0] jmp_idx;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        flush_idex;
    logic        halted;
    logic        addr_err;
    logic [15:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rom_instr = 32'hA000_0000 | rom_addr;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_instr  (rom_instr),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_pc      (br_pc),
        .br_off     (br_off),
        .jmp_en     (jmp_en),
        .jmp_idx    (jmp_idx),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_valid (ifid_valid),
        .flush_idex (flush_idex),
        .halted     (halted),
        .addr_err   (addr_err),
        .fetch_cnt  (fetch_cnt)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] br_pc;
        logic [15:0] br_off;
        logic        jmp;
        logic [25:0] jmp_idx;
        logic [31:0] e_rom;
        logic [31:0] e_ifpc;
        logic        e_v;
        logic        e_fl;
        logic        e_h;
        logic        e_ae;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic b, input logic [31:0] bpc,
                       input logic [15:0] boff, input logic j, input logic [25:0] ji,
                       input logic [31:0] e_rom, input logic [31:0] e_ifpc, input logic e_v,
                       input logic e_fl, input logic e_h, input logic e_ae, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.br_pc = bpc; v.br_off = boff;
        v.jmp = j; v.jmp_idx = ji;
        v.e_rom = e_rom; v.e_ifpc = e_ifpc; v.e_v = e_v; v.e_fl = e_fl;
        v.e_h = e_h; v.e_ae = e_ae; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Plain advance (or stall) with no redirect.
    task automatic adv(input logic s, input logic [31:0] e_rom, input logic [31:0] e_ifpc,
                       input logic e_v, input logic e_h, input logic e_ae, input logic [15:0] e_cnt);
        add(1'b0, s, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, e_rom, e_ifpc, e_v, 1'b0, e_h, e_ae, e_cnt);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e_instr;
        int cyc;

        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_pc = '0; br_off = '0;
        jmp_en = 1'b0; jmp_idx = '0;

        // reset, then in-range (28) and out-of-range (29) branch boundaries
        add(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 20, 7, 0, 0,      28, 0, 0, 1, 0, 0, 0);
        adv(0,                          28, 28, 1, 1, 0, 1);
        add(0, 0, 1, 20, 8, 0, 0,      28, 28, 0, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0);
        // free run up to PC=16
        for (int k = 1; k <= 16; k++) adv(0, 32'(k), 32'(k - 1), 1, 0, 0, 16'(k));
        // two-cycle stall at PC=16
        adv(1, 16, 15, 1, 0, 0, 16);
        adv(1, 16, 15, 1, 0, 0, 16);
        adv(0, 17, 16, 1, 0, 0, 17);
        adv(0, 18, 17, 1, 0, 0, 18);
        // forward branch 7+1+6=14, one bubble
        add(0, 0, 1, 7, 16'd6, 0, 0,   14, 17, 0, 1, 0, 0, 18);
        adv(0, 15, 14, 1, 0, 0, 19);
        // backward branch to 1 beats jump and stall
        add(0, 1, 1, 7, 16'hFFF9, 1, 28, 1, 14, 0, 1, 0, 0, 19);
        adv(0, 2, 1, 1, 0, 0, 20);
        for (int p = 2; p <= 27; p++) adv(0, 32'(p + 1), 32'(p), 1, 0, 0, 16'(19 + p));
        // last word delivered, then HALT holds (stall ignored)
        adv(0, 28, 28, 1, 1, 0, 47);
        adv(0, 28, 28, 0, 1, 0, 47);
        adv(1, 28, 28, 0, 1, 0, 47);
        // jump out of HALT
        add(0, 0, 0, 0, 0, 1, 3,       3, 28, 0, 1, 0, 0, 47);
        adv(0, 4, 3, 1, 0, 0, 48);
        // out-of-range jump: HALT, sticky addr_err
        add(0, 0, 0, 0, 0, 1, 40,      4, 3, 0, 1, 1, 1, 48);
        adv(0, 4, 3, 0, 1, 1, 48);
        add(0, 0, 0, 0, 0, 1, 5,       5, 3, 0, 1, 0, 1, 48);
        adv(0, 6, 5, 1, 0, 1, 49);
        adv(1, 6, 5, 1, 0, 1, 49);
        // reset wins over stall and branch
        add(1, 1, 1, 7, 16'd6, 0, 0,   0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; stall = vecs[i].stall; br_taken = vecs[i].br;
            br_pc = vecs[i].br_pc; br_off = vecs[i].br_off;
            jmp_en = vecs[i].jmp; jmp_idx = vecs[i].jmp_idx;
            step();
            e_instr = vecs[i].e_v ? (32'hA000_0000 | vecs[i].e_ifpc) : 32'h0;
            chk($sformatf("v%0d rom_addr", i),   rom_addr,          vecs[i].e_rom);
            chk($sformatf("v%0d ifid_pc", i),    ifid_pc,           vecs[i].e_ifpc);
            chk($sformatf("v%0d ifid_valid", i), 32'(ifid_valid),   32'(vecs[i].e_v));
            chk($sformatf("v%0d ifid_instr", i), ifid_instr,        e_instr);
            chk($sformatf("v%0d flush_idex", i), 32'(flush_idex),   32'(vecs[i].e_fl));
            chk($sformatf("v%0d halted", i),     32'(halted),       32'(vecs[i].e_h));
            chk($sformatf("v%0d addr_err", i),   32'(addr_err),     32'(vecs[i].e_ae));
            chk($sformatf("v%0d fetch_cnt", i),  32'(fetch_cnt),    32'(vecs[i].e_cnt));
        end

        // Saturation: keep looping the program by jumping to 0 whenever it halts.
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp_idx = 26'd0;
        cyc = 0;
        while (fetch_cnt != 16'hFFFF && cyc < 70000) begin
            jmp_en = halted;
            step();
            cyc++;
        end
        chk("sat reached", 32'(fetch_cnt), 32'hFFFF);
        for (int k = 0; k < 4; k++) begin
            jmp_en = halted;
            step();
        end
        jmp_en = 1'b0;
        chk("sat hold", 32'(fetch_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
